controlador_semaforo: RTL

- Traffic-light sequencer for a pedestrian crossing.
- Drives car and pedestrian lamps through a fixed phase cycle: green, amber, all-red, pedestrian-walk.
- Phase durations are measured in "ticks" produced by an internal modulo prescaler. Each phase counter counts ticks up to a programmed duration and then hands over to the next phase.
- Sits between the board clock and the lamp drivers. A debounced push-button pulse arrives on `peticion`.

---
 rtl/controlador_semaforo_pkg.sv | 32 +++
 rtl/controlador_semaforo_tick.sv | 42 ++++
 rtl/controlador_semaforo.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/controlador_semaforo_pkg.sv
// Shared definitions for the pedestrian-crossing sequencer: phase codes,
// lamp patterns and the width helper used to size counters.
package controlador_semaforo_pkg;

   // Phase codes, also exported on the estado debug port
   typedef enum logic [1:0] {
      VERDE    = 2'd0,
      AMBAR    = 2'd1,
      ROJO     = 2'd2,
      PEATONES = 2'd3
   } fase_t;

   // Car lamp patterns {rojo, ambar, verde}
   localparam logic [2:0] COCHES_VERDE = 3'b001;
   localparam logic [2:0] COCHES_AMBAR = 3'b010;
   localparam logic [2:0] COCHES_ROJO  = 3'b100;

   // Pedestrian lamp patterns {verde, rojo}
   localparam logic [1:0] PEATONES_ROJO  = 2'b01;
   localparam logic [1:0] PEATONES_VERDE = 2'b10;

   // ceil(log2(valor)) with a floor of one bit, usable in constant context
   function automatic int ancho_log2(input int valor);
      int ancho;
      ancho = 1;
      while ((1 << ancho) < valor) begin
         ancho = ancho + 1;
      end
      return ancho;
   endfunction

endpackage

// File: rtl/controlador_semaforo_tick.sv
// Free-running modulo-N prescaler producing a one-cycle terminal-count tick.
module prescaler_tick
   import controlador_semaforo_pkg::*;
#(
   parameter int MODULO = 50000000
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int              ANCHO  = ancho_log2(MODULO);
   localparam logic [ANCHO-1:0] ULTIMO = ANCHO'(MODULO - 1);

   logic [ANCHO-1:0] cuenta_reg;
   logic [ANCHO-1:0] cuenta_next;
   logic             terminal;

   assign terminal = (cuenta_reg == ULTIMO);

   // Advance only while enabled; wrap back to zero after the terminal count
   always_comb begin
      cuenta_next = cuenta_reg;
      if (enable) begin
         cuenta_next = terminal ? '0 : cuenta_reg + ANCHO'(1);
      end
   end

   // Count register with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         cuenta_reg <= '0;
      end else begin
         cuenta_reg <= cuenta_next;
      end
   end

   // Tick is suppressed while frozen or held in reset
   assign tick = enable & terminal & ~reset;

endmodule

// File: rtl/controlador_semaforo.sv
// Pedestrian-crossing sequencer: VERDE -> AMBAR -> ROJO -> PEATONES -> VERDE,
// with phase lengths counted in prescaler ticks and a latched walk request.
module controlador_semaforo
   import controlador_semaforo_pkg::*;
#(
   parameter int MODULO_PRESCALER = 50000000,
   parameter int T_VERDE          = 8,
   parameter int T_AMBAR          = 2,
   parameter int T_ROJO           = 1,
   parameter int T_PEATON         = 6
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       peticion,
   output logic [2:0] luz_coches,
   output logic [1:0] luz_peatones,
   output logic       ack_peticion,
   output logic [1:0] estado,
   output logic       tick
);

   localparam int T_MAX_VA = (T_VERDE > T_AMBAR) ? T_VERDE : T_AMBAR;
   localparam int T_MAX_RP = (T_ROJO > T_PEATON) ? T_ROJO : T_PEATON;
   localparam int T_MAX    = (T_MAX_VA > T_MAX_RP) ? T_MAX_VA : T_MAX_RP;
   localparam int PW       = ancho_log2(T_MAX);

   // Last counter value of each phase
   localparam logic [PW-1:0] FIN_VERDE  = PW'(T_VERDE - 1);
   localparam logic [PW-1:0] FIN_AMBAR  = PW'(T_AMBAR - 1);
   localparam logic [PW-1:0] FIN_ROJO   = PW'(T_ROJO - 1);
   localparam logic [PW-1:0] FIN_PEATON = PW'(T_PEATON - 1);

   fase_t         estado_reg;
   fase_t         estado_next;
   logic [PW-1:0] fase_cnt_reg;
   logic [PW-1:0] fase_cnt_next;
   logic          latch_reg;
   logic          latch_next;
   logic [2:0]    coches_reg;
   logic [2:0]    coches_next;
   logic [1:0]    peatones_reg;
   logic [1:0]    peatones_next;
   logic          ack_reg;
   logic          ack_next;
   logic          tick_int;
   logic          pendiente;
   logic          entrada_peatones;

   prescaler_tick #(
      .MODULO(MODULO_PRESCALER)
   ) u_prescaler (
      .clock (clock),
      .reset (reset),
      .enable(enable),
      .tick  (tick_int)
   );

   assign pendiente = latch_reg | peticion;

   // Next phase and phase counter; everything moves only on tick cycles
   always_comb begin
      estado_next   = estado_reg;
      fase_cnt_next = fase_cnt_reg;
      if (tick_int) begin
         unique case (estado_reg)
            VERDE: begin
               // Counter saturates here so green can be held indefinitely
               if (fase_cnt_reg == FIN_VERDE) begin
                  if (pendiente) estado_next = AMBAR;
               end else begin
                  fase_cnt_next = fase_cnt_reg + PW'(1);
               end
            end
            AMBAR: begin
               if (fase_cnt_reg == FIN_AMBAR) estado_next = ROJO;
               else fase_cnt_next = fase_cnt_reg + PW'(1);
            end
            ROJO: begin
               if (fase_cnt_reg == FIN_ROJO) estado_next = PEATONES;
               else fase_cnt_next = fase_cnt_reg + PW'(1);
            end
            PEATONES: begin
               if (fase_cnt_reg == FIN_PEATON) estado_next = VERDE;
               else fase_cnt_next = fase_cnt_reg + PW'(1);
            end
         endcase
         if (estado_next != estado_reg) fase_cnt_next = '0;
      end
   end

   // Request latch, grant pulse and lamp decode from the upcoming phase
   always_comb begin
      entrada_peatones = (estado_next == PEATONES) && (estado_reg != PEATONES);
      latch_next       = latch_reg;
      if (entrada_peatones) begin
         // Granting consumes the request, including one arriving this cycle
         latch_next = 1'b0;
      end else if (peticion && (estado_reg != PEATONES)) begin
         latch_next = 1'b1;
      end
      ack_next      = entrada_peatones;
      coches_next   = COCHES_VERDE;
      peatones_next = PEATONES_ROJO;
      unique case (estado_next)
         VERDE: begin
            coches_next   = COCHES_VERDE;
            peatones_next = PEATONES_ROJO;
         end
         AMBAR: begin
            coches_next   = COCHES_AMBAR;
            peatones_next = PEATONES_ROJO;
         end
         ROJO: begin
            coches_next   = COCHES_ROJO;
            peatones_next = PEATONES_ROJO;
         end
         PEATONES: begin
            coches_next   = COCHES_ROJO;
            peatones_next = PEATONES_VERDE;
         end
      endcase
   end

   // State, counter, latch and registered outputs with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_reg   <= VERDE;
         fase_cnt_reg <= '0;
         latch_reg    <= 1'b0;
         coches_reg   <= COCHES_VERDE;
         peatones_reg <= PEATONES_ROJO;
         ack_reg      <= 1'b0;
      end else begin
         estado_reg   <= estado_next;
         fase_cnt_reg <= fase_cnt_next;
         latch_reg    <= latch_next;
         coches_reg   <= coches_next;
         peatones_reg <= peatones_next;
         ack_reg      <= ack_next;
      end
   end

   assign luz_coches   = coches_reg;
   assign luz_peatones = peatones_reg;
   assign ack_peticion = ack_reg;
   assign estado       = estado_reg;
   assign tick         = tick_int;

endmodule
